// File: rtl/mod_audio_pwm_out.sv
// mod_audio_pwm_out
// Buffers PCM samples in a small FIFO and plays one sample per rising edge of
// the divided sample clock as single-bit PWM. An empty FIFO at a sample
// strobe is flagged as a sticky underrun; playback never stalls.
module mod_audio_pwm_out #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk_in,
  input  logic                          i_rst,
  input  logic                          i_enable,
  input  logic                          i_sample_clk,
  input  logic [DATA_W-1:0]             i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_underrun,
  output logic                          o_pwm
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  // Occupancy that means "full"; pointers alone cannot tell full from empty.
  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LEVEL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
  localparam logic [DATA_W-1:0] CNT_ONE   = DATA_W'(1);

  // Sample storage. Deliberately not reset so it maps onto RAM primitives.
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic                  prev_reg;
  logic [PTR_W-1:0]      wr_ptr_reg,     wr_ptr_next;
  logic [PTR_W-1:0]      rd_ptr_reg,     rd_ptr_next;
  logic [LVL_W-1:0]      level_reg,      level_next;
  logic [DATA_W-1:0]     cur_sample_reg, cur_sample_next;
  logic [DATA_W-1:0]     pwm_cnt_reg,    pwm_cnt_next;
  logic                  underrun_reg,   underrun_next;
  logic                  pwm_reg,        pwm_next;

  logic                  strobe;
  logic                  fifo_empty;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_W-1:0]     head_data;

  // Rising edge of the sample clock, suppressed while playback is disabled.
  // prev_reg resets high so a sample clock already high at reset release is
  // not mistaken for an edge.
  assign strobe     = i_sample_clk & ~prev_reg & i_enable;
  assign fifo_empty = (level_reg == '0);

  // Ready comes from the registered level only, never from this cycle's read,
  // so a strobe on a full FIFO does not open a same-cycle write path.
  assign o_ready    = (level_reg != FULL_LEVEL);
  assign wr_en      = i_valid & o_ready;

  // The read looks at pre-write state: a write into an empty FIFO cannot be
  // consumed by a strobe on the same edge.
  assign rd_en      = strobe & ~fifo_empty;
  assign head_data  = mem[rd_ptr_reg];

  assign o_level    = level_reg;
  assign o_underrun = underrun_reg;
  assign o_pwm      = pwm_reg;

  // FIFO storage write port.
  always_ff @(posedge i_clk_in) begin
    if (wr_en) begin
      mem[wr_ptr_reg] <= i_data;
    end
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    level_next  = level_reg;

    if (wr_en) begin
      wr_ptr_next = wr_ptr_reg + PTR_ONE;
    end
    if (rd_en) begin
      rd_ptr_next = rd_ptr_reg + PTR_ONE;
    end

    case ({wr_en, rd_en})
      2'b10:   level_next = level_reg + LEVEL_ONE;
      2'b01:   level_next = level_reg - LEVEL_ONE;
      default: level_next = level_reg;
    endcase
  end

  // Sample playout: load the head on a strobe, flag strobes that find no data.
  always_comb begin
    cur_sample_next = cur_sample_reg;
    underrun_next   = underrun_reg;

    if (rd_en) begin
      cur_sample_next = head_data;
    end
    if (strobe && fifo_empty) begin
      underrun_next = 1'b1;
    end
  end

  // PWM phase counter: restarts on every strobe, freezes while disabled.
  always_comb begin
    pwm_cnt_next = pwm_cnt_reg;
    if (strobe) begin
      pwm_cnt_next = '0;
    end else if (i_enable) begin
      pwm_cnt_next = pwm_cnt_reg + CNT_ONE;
    end
  end

  // PWM comparator; registered so the pin is glitch-free.
  always_comb begin
    pwm_next = i_enable & (pwm_cnt_reg < cur_sample_reg);
  end

  // State registers, all returned to idle immediately on reset.
  always_ff @(posedge i_clk_in or posedge i_rst) begin
    if (i_rst) begin
      prev_reg       <= 1'b1;
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      cur_sample_reg <= '0;
      pwm_cnt_reg    <= '0;
      underrun_reg   <= 1'b0;
      pwm_reg        <= 1'b0;
    end else begin
      prev_reg       <= i_sample_clk;
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      cur_sample_reg <= cur_sample_next;
      pwm_cnt_reg    <= pwm_cnt_next;
      underrun_reg   <= underrun_next;
      pwm_reg        <= pwm_next;
    end
  end

endmodule

// File: tb/tb_mod_audio_pwm_out.sv
// Testbench for mod_audio_pwm_out (DATA_W=8, FIFO_DEPTH=4).
// A queue-based reference model tracks FIFO contents, the playing sample and
// the PWM phase; table vectors and hand-written sequences cover corner cases.
module tb_mod_audio_pwm_out;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          sclk;
  logic [DW-1:0] data;
  logic          valid;
  logic          ready;
  logic [LW-1:0] level;
  logic          under;
  logic          pwm;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int q[$];
  int m_cur;
  int m_phase;
  bit m_under;
  bit m_prev;
  bit m_pwm;

  typedef struct {
    bit v;
    int d;
    bit e;
    bit s;
    int lvl;
    bit rdy;
    bit pw;
    bit un;
  } vec_t;

  vec_t tbl[8];

  mod_audio_pwm_out #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .i_clk_in    (clk),
    .i_rst       (rst),
    .i_enable    (en),
    .i_sample_clk(sclk),
    .i_data      (data),
    .i_valid     (valid),
    .o_ready     (ready),
    .o_level     (level),
    .o_underrun  (under),
    .o_pwm       (pwm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cur   = 0;
    m_phase = 0;
    m_under = 0;
    m_prev  = 1;
    m_pwm   = 0;
  endtask

  // One clock edge of the behavioural model, using the inputs now applied.
  task automatic model_edge();
    bit strobe;
    bit acc;
    int sz;
    sz     = q.size();
    strobe = sclk && !m_prev && en;
    acc    = valid && (sz < DEPTH);
    m_pwm  = en && ((m_phase % 256) < m_cur);
    if (strobe) begin
      if (sz > 0) m_cur = q.pop_front();
      else        m_under = 1;
      m_phase = 0;
    end else if (en) begin
      m_phase++;
    end
    if (acc) q.push_back(int'(data));
    m_prev = sclk;
  endtask

  task automatic check_model();
    check("level", int'(level), q.size());
    check("ready", int'(ready), int'(q.size() != DEPTH));
    check("underrun", int'(under), int'(m_under));
    check("pwm", int'(pwm), int'(m_pwm));
  endtask

  task automatic step(input bit v, input int d, input bit e, input bit s);
    valid = v;
    data  = d[DW-1:0];
    en    = e;
    sclk  = s;
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    valid = 0;
    en    = 0;
    sclk  = 0;
    rst   = 1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  // Produce a sample-clock rising edge, then count PWM highs over one period.
  task automatic play_and_count(input string name, input int exp_high);
    int hi;
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      step(0, 0, 1, 1);
      if (i == 0) check({name, "_first"}, int'(pwm), int'(exp_high > 0));
      if (pwm) hi++;
    end
    check({name, "_duty"}, hi, exp_high);
  endtask

  initial begin
    // Fill-to-full vectors, starting right after reset (enable low for writes)
    tbl[0] = '{1, 8'h11, 0, 0, 1, 1, 0, 0};
    tbl[1] = '{1, 8'h22, 0, 0, 2, 1, 0, 0};
    tbl[2] = '{1, 8'h33, 0, 0, 3, 1, 0, 0};
    tbl[3] = '{1, 8'h44, 0, 0, 4, 0, 0, 0};
    tbl[4] = '{1, 8'h55, 0, 0, 4, 0, 0, 0};  // 5th held off
    tbl[5] = '{1, 8'h55, 1, 1, 3, 1, 0, 0};  // strobe on full, no write
    tbl[6] = '{1, 8'h55, 1, 1, 4, 0, 1, 0};  // 5th accepted next cycle
    tbl[7] = '{0, 8'h00, 1, 1, 4, 0, 1, 0};  // level high, no second strobe

    // Reset state, checked while reset is still asserted
    rst   = 1;
    en    = 0;
    sclk  = 1;
    valid = 0;
    data  = '0;
    model_reset();
    #3;
    check("rst_level", int'(level), 0);
    check("rst_ready", int'(ready), 1);
    check("rst_pwm", int'(pwm), 0);
    check("rst_underrun", int'(under), 0);
    @(posedge clk);
    #1;
    rst = 0;

    // Sample clock already high at reset release is not an edge
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      check("no_edge_at_release", int'(under), 0);
    end

    // Build a busy state, then reset asynchronously mid-cycle
    step(0, 0, 1, 0);
    step(1, 8'hFF, 1, 0);
    step(0, 0, 1, 1);      // pops 0xFF
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);      // underrun strobe
    step(1, 1, 1, 1);
    step(1, 2, 1, 1);
    step(1, 3, 1, 1);
    check("pre_rst_level", int'(level), 3);
    check("pre_rst_underrun", int'(under), 1);
    check("pre_rst_pwm", int'(pwm), 1);
    #2;
    rst = 1;
    #1;
    check("async_rst_level", int'(level), 0);
    check("async_rst_ready", int'(ready), 1);
    check("async_rst_pwm", int'(pwm), 0);
    check("async_rst_underrun", int'(under), 0);
    valid = 0;
    en    = 0;
    sclk  = 0;
    model_reset();
    @(posedge clk);
    #1;
    rst = 0;

    // Fill to full, table driven
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].e, tbl[i].s);
      check($sformatf("tbl%0d_level", i), int'(level), tbl[i].lvl);
      check($sformatf("tbl%0d_ready", i), int'(ready), int'(tbl[i].rdy));
      check($sformatf("tbl%0d_pwm", i), int'(pwm), int'(tbl[i].pw));
      check($sformatf("tbl%0d_underrun", i), int'(under), int'(tbl[i].un));
    end

    // Duty cycle
    do_reset();
    step(1, 8'h40, 1, 0);
    play_and_count("duty40", 64);
    step(1, 8'h00, 1, 0);
    step(1, 8'hFF, 1, 0);
    play_and_count("duty00", 0);
    play_and_count("dutyFF", 255);

    // Underrun after playing 0x80
    do_reset();
    step(1, 8'h80, 1, 0);
    play_and_count("play80", 128);
    play_and_count("under80", 128);
    check("under_flag", int'(under), 1);
    check("under_level", int'(level), 0);
    for (int i = 0; i < 20; i++) step(i % 3 == 0, i, 1, 0);
    check("under_sticky", int'(under), 1);

    // Simultaneous write and strobe at level 2
    do_reset();
    step(1, 10, 1, 0);
    step(1, 20, 1, 0);
    check("sim2_pre_level", int'(level), 2);
    step(1, 30, 1, 1);
    check("sim2_level", int'(level), 2);
    check("sim2_underrun", int'(under), 0);
    play_and_count("sim2_order_b", 20);
    play_and_count("sim2_order_c", 30);

    // Simultaneous write and strobe on an empty FIFO
    do_reset();
    step(0, 0, 1, 0);
    step(1, 50, 1, 1);
    check("sim0_underrun", int'(under), 1);
    check("sim0_level", int'(level), 1);
    play_and_count("sim0_play", 50);

    // Enable gating
    do_reset();
    step(1, 60, 1, 0);
    step(1, 70, 1, 0);
    step(0, 0, 1, 1);      // pops 60
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 60; i++) begin
      step(0, 0, 0, (i / 3) % 2);
      check("gate_level", int'(level), 1);
      check("gate_pwm", int'(pwm), 0);
    end
    step(0, 0, 0, 1);
    step(0, 0, 1, 1);      // re-enable with sample clock high
    check("reenable_no_strobe", int'(level), 1);
    for (int i = 0; i < 60; i++) step(0, 0, 1, 1);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    check("reenable_next_edge", int'(level), 0);

    // Randomized operation against the model
    do_reset();
    begin
      bit s_r;
      s_r = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 5) == 0) s_r = ~s_r;
        step($urandom_range(0, 9) < 3, int'($urandom_range(0, 255)),
             $urandom_range(0, 7) != 0, s_r);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_audio_pwm_out.md
# mod_audio_pwm_out

Audio output stage downstream of the clock divider. The block buffers PCM samples from an upstream producer in a small FIFO. On each rising edge of the divided sample clock it pops one sample and plays it out as single-bit PWM on `i_clk_in`. Underruns are flagged, never stalled. The pin-level audio output of the design.

## Interface
- `DATA_W`, default 8: sample width in bits (unsigned); PWM period is 2^DATA_W cycles.
- `FIFO_DEPTH`, default 16: FIFO entries; power of two, ≥2.
- `i_clk_in`  input  1  system clock; all logic on its rising edge.
- `i_rst`  input  1  reset, asynchronous, active-high.
- `i_enable`  input  1  playback enable.
- `i_sample_clk`  input  1  divided sample clock from the clock divider; same domain as `i_clk_in`, only its rising edge is used.
- `i_data`  input  DATA_W  sample from producer.
- `i_valid`  input  1  `i_data` valid.
- `o_ready`  output  1  FIFO can accept a write.
- `o_level`  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
- `o_underrun`  output  1  sticky: a strobe found the FIFO empty.
- `o_pwm`  output  1  PWM audio output, registered.

## Operation
- Edge detect: register `prev` samples `i_sample_clk` every cycle, regardless of `i_enable`. `strobe = i_sample_clk & ~prev & i_enable`. `prev` resets to 1, so a high `i_sample_clk` at reset release is not an edge.
- FIFO write: accepted when `i_valid & o_ready`. `o_ready = (o_level != FIFO_DEPTH)`, derived from registered level only. Writes are accepted while `i_enable` is low.
- FIFO read on `strobe`:
  - `o_level > 0`: head loads into `cur_sample`, read pointer advances.
  - `o_level == 0`: `cur_sample` holds its previous value and `o_underrun` sets. `o_underrun` clears only on reset.
- Simultaneous write and strobe:
  - Not full, not empty: both happen; level unchanged.
  - Empty: underrun is flagged, the write lands, and the level becomes 1. The read sees pre-write state; there is no bypass.
  - Full: no write (`o_ready` is 0), the read happens, and the level becomes FIFO_DEPTH-1.
- Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by `o_level`.
- PWM:
  - `pwm_cnt` is a DATA_W-bit counter that increments each enabled cycle and wraps at 2^DATA_W-1 → 0.
  - Every `strobe` (including underrun strobes) forces `pwm_cnt` to 0.
  - `o_pwm <= i_enable & (pwm_cnt < cur_sample)`. Sample 0 gives a constant low; sample 2^DATA_W-1 gives high for 2^DATA_W-1 of every 2^DATA_W cycles.
- `i_enable` low:
  - `pwm_cnt` holds and no strobes occur.
  - `o_pwm` goes low on the next edge.
  - FIFO contents and `cur_sample` are kept.
- Reset mid-operation: all state returns immediately to its reset value and FIFO contents are discarded. Storage RAM need not be cleared.

## Timing
- Reset values:
  - `o_pwm` 0, `o_underrun` 0, `o_level` 0, `o_ready` 1.
  - Internal: `cur_sample` 0, `pwm_cnt` 0, pointers 0, `prev` 1.
- Write latency: the entry is counted in `o_level` on the edge that accepts it; `o_ready` updates the same cycle after that edge.
- Strobe: `i_sample_clk` goes high at edge k-1 (`prev` still 0) → at edge k, `cur_sample`, `pwm_cnt=0`, `o_level` and `o_underrun` update. `o_pwm` at edge k+1 reflects the new sample compared against count 0.
- One read per `i_sample_clk` rising edge; a high level lasting many cycles produces exactly one strobe.

## Test plan
- Reset and idle:
  - Stimulus: assert `i_rst` mid-stream with `o_level=3`.
  - Required: `o_level=0`, `o_ready=1`, `o_pwm=0`, `o_underrun=0` immediately and without a clock edge.
- Fill to full (DATA_W=8, FIFO_DEPTH=4):
  - Stimulus: write 5 samples back-to-back with `i_enable=0`.
  - Required: 4 accepted, `o_ready=0` after the 4th, `o_level=4`, 5th held off. One strobe → `o_level=3` and the 5th is accepted the next cycle.
- Duty cycle:
  - Stimulus: push 0x40, then one strobe.
  - Required: over the next 256 cycles `o_pwm` is high exactly 64 cycles, starting 1 cycle after the strobe edge. Sample 0x00 → 0 high cycles; 0xFF → 255 high cycles.
- Underrun:
  - Stimulus: strobe with the FIFO empty after playing 0x80.
  - Required: `o_underrun=1` and stays 1; `cur_sample` stays 0x80 (128 high per 256); `o_level` stays 0.
- Simultaneous events:
  - Write with `i_valid`+strobe on the same edge, with `o_level=2` → `o_level` stays 2 and FIFO order is preserved.
  - Same with `o_level=0` → underrun set and `o_level=1`.
- Enable gating:
  - Stimulus: deassert `i_enable` across several `i_sample_clk` edges.
  - Required: no pops, `o_pwm=0`, `pwm_cnt` frozen. Re-enable while `i_sample_clk` is high produces no strobe until its next rising edge.
